// File: rtl/stream_mux_n_1_if.sv
// Handshake bundle for the N:1 stream multiplexer: per-channel inputs on one side,
// a single registered stream on the other.
`timescale 1ns/1ps
interface stream_mux_n_1_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int SEL_W = $clog2(N);

  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;

  // Environment side: drives channel inputs, control and downstream ready.
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  // Multiplexer side.
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream multiplexer with fixed-select or round-robin grant and a
// single registered output stage that sustains one word per cycle.
`timescale 1ns/1ps
module stream_mux_n_1 #(
  parameter int N = 4,
  parameter int W = 4
) (
  input logic               clk,
  input logic               rst_n,
  stream_mux_n_1_if.slave   bus
);
  localparam int SEL_W = $clog2(N);
  typedef logic [SEL_W-1:0] idx_t;

  // First valid channel at or above ptr, wrapping; MSB of the result flags a hit.
  // Scanning offsets downward lets the smallest offset overwrite any larger one.
  function automatic logic [SEL_W:0] rr_search(input logic [N-1:0] valid, input idx_t ptr);
    logic [SEL_W:0] res;
    idx_t           idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + idx_t'(k);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Only the selected slice is ever read, so other channels' data cannot leak.
  function automatic logic [W-1:0] pick_data(input logic [N*W-1:0] data, input idx_t idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == idx_t'(i)) r = data[i*W +: W];
    end
    return r;
  endfunction

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  idx_t           out_chan_q,  out_chan_d;
  idx_t           rr_ptr_q,    rr_ptr_d;

  logic           free;
  logic           grant_vld;
  idx_t           grant_idx;
  logic [SEL_W:0] rr_hit;
  logic           xfer;
  logic [N-1:0]   ready_vec;

  // Grant decision: depends only on valids, mode/sel, pointer and output occupancy.
  always_comb begin
    free      = !out_valid_q || bus.out_ready;
    rr_hit    = rr_search(bus.in_valid, rr_ptr_q);
    grant_vld = 1'b0;
    grant_idx = '0;
    if (bus.mode) begin
      grant_vld = rr_hit[SEL_W];
      grant_idx = rr_hit[SEL_W-1:0];
    end else begin
      grant_vld = bus.in_valid[bus.sel];
      grant_idx = bus.sel;
    end
    xfer      = grant_vld && free && rst_n;
    ready_vec = '0;
    if (xfer) ready_vec[grant_idx] = 1'b1;
  end

  assign bus.in_ready = ready_vec;

  // Output register next state: load on transfer, drop valid when drained, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_data(bus.in_data, grant_idx);
      out_chan_d  = grant_idx;
      if (bus.mode) rr_ptr_d = grant_idx + idx_t'(1);
    end else if (free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: doc/stream_mux_n_1.md
STREAM_MUX_N_1 -- requirements
Module: stream_mux_n_1

Interface
REQ-001 Parameter N, default 4: number of input channels; power of two, 2..16.
REQ-002 Parameter W, default 4: data width per channel, 1..64.
REQ-003 Localparam SEL_W = $clog2(N): channel index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = fixed select by sel, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used when mode = 0.
REQ-008 in_valid  input  N  per-channel data valid.
REQ-009 in_ready  output  N  per-channel accept; combinational.
REQ-010 in_data  input  N*W  channel i at bits [i*W +: W].
REQ-011 out_valid  output  1  registered output holds valid data.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  W  registered data of the granted channel.
REQ-014 out_chan  output  SEL_W  registered index of the channel that produced out_data.

Function
REQ-015 Output stage SHALL be one register; it is "free" when out_valid = 0 or out_ready = 1.
REQ-016 Transfer on a channel SHALL occur when in_valid[i] && in_ready[i]; at most one in_ready bit is high per cycle.
REQ-017 Mode 0: in_ready[sel] = in_valid[sel] && free; all other in_ready bits = 0.
REQ-018 Mode 1: grant the first valid channel searching upward from rr_ptr with wrap from N-1 to 0; in_ready[grant] = free.
REQ-019 After a mode-1 transfer from channel g, rr_ptr SHALL become (g+1) mod N; no transfer or mode-0 transfer leaves rr_ptr unchanged.
REQ-020 On a transfer, out_data/out_chan SHALL load the granted channel's data/index next edge and out_valid = 1 (latency 1 cycle).
REQ-021 When free with no transfer, out_valid SHALL go to 0 next edge; out_data/out_chan hold their last values.
REQ-022 Stall (out_valid && !out_ready): out_data, out_chan, out_valid SHALL hold; all in_ready = 0.
REQ-023 Simultaneous drain and transfer (out_ready = 1, new grant) SHALL sustain one word per cycle with no bubble.
REQ-024 Data of non-granted channels, including X, SHALL never reach out_data or affect control.
REQ-025 mode and sel are sampled each cycle; a change affects only the next grant decision; already registered output is unaffected.
REQ-026 No valid inputs (in_valid = 0): in_ready = 0, no state change except REQ-021.
REQ-027 in_ready SHALL NOT depend on in_data; no combinational path from in_ready back to in_valid.

Reset
REQ-028 rst_n = 0 SHALL immediately (asynchronously) set out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0.
REQ-029 While rst_n = 0, in_ready SHALL be all zero.
REQ-030 Reset mid-stall SHALL discard the held word; first grant after release starts at channel 0 in mode 1.

Verification (N = 4, W = 4)
REQ-031 Mode 0, in_data = {d,c,b,a} (ch3..ch0), in_valid = 1111, out_ready = 1, sel stepping 0,1,2,3 -> out_data a,b,c,d, out_chan 0..3, one cycle after each.
REQ-032 Mode 1, all four valid and held, out_ready = 1 -> grants 0,1,2,3,0 on consecutive cycles; out_valid stays 1.
REQ-033 Mode 1, in_valid = 0101 after grant of ch0 -> next grant ch2, then ch0; ch1/ch3 in_data = X never appears on out_data.
REQ-034 out_valid = 1, out_data = 7, out_ready = 0 for 3 cycles with all inputs valid -> out_data stays 7, in_ready = 0000; out_ready = 1 -> next word loads next edge.
REQ-035 Mode 0, sel = 2, in_valid = 1011 -> in_ready = 0000, out_valid falls to 0 after drain; raising in_valid[2] with data 3 -> out_data = 3, out_chan = 2.
REQ-036 Assert rst_n = 0 mid-stall between edges -> out_valid = 0 and out_data = 0 immediately; after release mode 1 first grant is lowest valid channel from 0.
